// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer with a registered head entry (zero while empty).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] rd_after;
  fetch_entry_t  head_reg, head_next;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = head_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // The head register is refilled either from storage or, when the buffer is
  // about to run dry, straight from the incoming word.
  always_comb begin
    count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
    rd_after   = rd_ptr_reg + AW'(pop);
    head_next  = head_reg;
    if (flush || (count_next == '0)) begin
      head_next = '0;
    end else if (push || pop) begin
      if (count_reg == (AW+1)'(pop)) begin
        head_next = wdata;
      end else begin
        head_next = mem_reg[rd_after];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, redirect/halt FSM and decode handshake.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt_o / flush_cnt_o performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         push, pop, full, empty;
  fetch_entry_t wdata, head;

  assign wdata         = '{pc: pc_reg, instr: imem_instr_i};
  assign instr_valid_o = !empty && !redirect_valid_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign imem_addr_o   = pc_reg;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;
  assign halted_o      = (state_reg == HALT);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    if (redirect_valid_i) begin
      state_next = RUN;
      pc_next    = align_word(redirect_pc_i);
    end else begin
      unique case (state_reg)
        IDLE: state_next = RUN;
        RUN: begin
          // A slot exists when there is room, including room freed by this cycle's pop.
          if (!full || pop) begin
            if (HALT_ON_ZERO && (imem_instr_i == '0)) begin
              state_next = HALT;
            end else begin
              push    = 1'b1;
              pc_next = pc_reg + 32'(INSTR_BYTES);
            end
          end
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid_i),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pop)              fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (redirect_valid_i) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random stimulus against a queue model.
module tb_fetch_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] ADDI = 32'h0010_8093;
  localparam logic [31:0] SW   = 32'h0020_A023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready, halted;
  logic [31:0] instr, pc;
  logic [31:0] prog [64];

  logic [31:0] imem_addr2, imem_instr2, instr2, pc2;
  logic        valid2, halted2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt, fetch_cnt2, flush_cnt2;
`endif

  assign imem_instr  = prog[imem_addr[7:2]];
  assign imem_instr2 = ~imem_addr2;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc), .halted_o(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  fetch_ctrl #(
    .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2), .HALT_ON_ZERO(1'b0)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_addr_o(imem_addr2), .imem_instr_i(imem_instr2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(valid2), .instr_ready_i(1'b1),
    .instr_o(instr2), .pc_o(pc2), .halted_o(halted2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt2), .flush_cnt_o(flush_cnt2)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch buffer is a queue of {pc, instr}; fetching is
  // "take the next word if there is room", stopping on a zero word.
  logic [63:0] q[$];
  logic [31:0] pc_m = 32'h0;
  bit          halted_m = 1'b0;
  bit          idle_m = 1'b1;
  int unsigned fcnt_m = 0, flcnt_m = 0;
  int          m_n;
  bit          m_pop;
  logic [31:0] m_word;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      pc_m = 32'h0; halted_m = 1'b0; idle_m = 1'b1; fcnt_m = 0; flcnt_m = 0;
    end else if (redirect_valid) begin
      q.delete();
      pc_m = {redirect_pc[31:2], 2'b00}; halted_m = 1'b0; idle_m = 1'b0;
      flcnt_m++;
    end else if (idle_m) begin
      idle_m = 1'b0;
    end else begin
      m_n    = q.size();
      m_pop  = (m_n > 0) && instr_ready;
      m_word = prog[pc_m[7:2]];
      if (m_pop) begin
        void'(q.pop_front());
        fcnt_m++;
      end
      if (!halted_m && (m_n < int'(DEPTH) || m_pop)) begin
        if (m_word == 32'h0) halted_m = 1'b1;
        else begin
          q.push_back({pc_m, m_word});
          pc_m = pc_m + 32'd4;
        end
      end
    end
  end

  logic        exp_valid;
  logic [63:0] exp_head;

  always @(negedge clk) begin
    exp_valid = (q.size() > 0) && !redirect_valid;
    exp_head  = (q.size() > 0) ? q[0] : 64'h0;
    chk("valid",     {31'b0, instr_valid}, {31'b0, exp_valid});
    chk("pc_o",      pc,        exp_head[63:32]);
    chk("instr_o",   instr,     exp_head[31:0]);
    chk("imem_addr", imem_addr, pc_m);
    chk("halted",    {31'b0, halted}, {31'b0, halted_m});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, fcnt_m);
    chk("flush_cnt", flush_cnt, flcnt_m);
`endif
    if (rst_ni && instr_valid && instr_ready)
      $display("xfer pc=%h instr=%h", pc, instr);
  end

  // Capture the first three words delivered by the wrapping-PC instance.
  int          caps = 0;
  bit          snap_done = 1'b0;
  logic [31:0] cap_pc [3];
  logic [31:0] cap_instr0 = 32'h0;
  logic [31:0] snap_fetch = 32'hFFFF_FFFF, snap_flush = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    if (caps == 3 && !snap_done) begin
      snap_done = 1'b1;
`ifdef FETCH_PERF_CNT_EN
      snap_fetch = fetch_cnt2;
      snap_flush = flush_cnt2;
`endif
    end
    if (rst_ni && valid2 && caps < 3) begin
      if (caps == 0) cap_instr0 = instr2;
      cap_pc[caps] = pc2;
      caps++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_test1();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0] = ADD; prog[1] = ADDI; prog[2] = SW;
  endtask

  // Entered with reset asserted, ready=1, no redirect.
  task automatic run_test1();
    rst_ni = 1'b1;
    step(); chk("t1_idle_valid", {31'b0, instr_valid}, 32'd0);
    step(); chk("t1_valid", {31'b0, instr_valid}, 32'd1);
            chk("t1_pc0", pc, 32'h0); chk("t1_add", instr, ADD);
    step(); chk("t1_pc4", pc, 32'h4); chk("t1_addi", instr, ADDI);
    step(); chk("t1_pc8", pc, 32'h8); chk("t1_sw", instr, SW);
    step(); chk("t1_halted", {31'b0, halted}, 32'd1);
            chk("t1_drained", {31'b0, instr_valid}, 32'd0);
            chk("t1_addr", imem_addr, 32'hC);
    step(); chk("t1_addr_hold", imem_addr, 32'hC);
  endtask

  initial begin
    rst_ni = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    load_test1();
    repeat (3) step();
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    run_test1();

    // Redirect out of HALT replays the program.
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    #1 chk("t4_mask", {31'b0, instr_valid}, 32'd0);
    step(); redirect_valid = 1'b0;
    chk("t4_unhalt", {31'b0, halted}, 32'd0);
    chk("t4_addr", imem_addr, 32'h0);
    step(); chk("t4_pc0", pc, 32'h0);
    repeat (4) step();
    chk("t4_rehalt", {31'b0, halted}, 32'd1);

    // Backpressure fills the buffer, then drains in order.
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); redirect_valid = 1'b0;
    repeat (6) step();
    chk("t2_addr", imem_addr, 32'h8); chk("t2_pc0", pc, 32'h0);
    chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    step();
    chk("t2_addr_stable", imem_addr, 32'h8); chk("t2_pc0_stable", pc, 32'h0);
    instr_ready = 1'b1;
    step(); chk("t2_pc4", pc, 32'h4);
    step(); chk("t2_pc8", pc, 32'h8);
    step(); chk("t2_empty", {31'b0, instr_valid}, 32'd0);
            chk("t2_halted", {31'b0, halted}, 32'd1);

    // Mid-stream redirect to an unaligned target.
    for (int i = 4; i < 16; i++) prog[i] = 32'h1000_0013 + 32'(i);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(); redirect_valid = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    #1 chk("t3_mask", {31'b0, instr_valid}, 32'd0);
    step(); redirect_valid = 1'b0;
    chk("t3_addr", imem_addr, 32'h20);
    chk("t3_flushed", {31'b0, instr_valid}, 32'd0);
    step(); chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_pc", pc, 32'h20); chk("t3_instr", instr, 32'h1000_001B);

    // Random traffic against the model.
    for (int i = 0; i < 64; i++) prog[i] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
    for (int c = 0; c < 800; c++) begin
      step();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) prog[$urandom_range(0, 63)] = $urandom;
    end

    // Asynchronous reset with a full buffer, then restart timing.
    for (int i = 0; i < 64; i++) prog[i] = 32'(i + 1);
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); redirect_valid = 1'b0;
    repeat (4) step();
    chk("t5_full_valid", {31'b0, instr_valid}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t5_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_instr", instr, 32'h0); chk("t5_pc", pc, 32'h0);
    chk("t5_halted", {31'b0, halted}, 32'd0); chk("t5_addr", imem_addr, 32'h0);
    load_test1(); instr_ready = 1'b1;
    step(); step();
    run_test1();

    // Wrapping PC instance.
    chk("t6_caps", 32'(caps), 32'd3);
    chk("t6_pc0", cap_pc[0], 32'hFFFF_FFFC);
    chk("t6_pc1", cap_pc[1], 32'h0000_0000);
    chk("t6_pc2", cap_pc[2], 32'h0000_0004);
    chk("t6_instr0", cap_instr0, 32'h0000_0003);
    chk("t6_halted", {31'b0, halted2}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_fetch_cnt", snap_fetch, 32'd3);
    chk("t6_flush_cnt", snap_flush, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
